// File: rtl/ov9281_frame_packer.sv
// rtl/ov9281_frame_packer.sv - aligns OV9281 capture words to vsync frames, tags sof/eof, FWFT buffers them
// and reports per-frame word count and length/overflow status.
module ov9281_frame_packer #(
    parameter int FRAME_WORDS = 256000,
    parameter int CNT_W       = 19,
    parameter int FIFO_AW     = 4
) (
    input  logic             camera_pclk,
    input  logic             rst_n,
    input  logic             init_done,
    input  logic             camera_vsync,
    input  logic             in_req,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic             frame_done,
    output logic             frame_err,
    output logic [CNT_W-1:0] word_cnt,
    output logic             overflow
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACTIVE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             vsync_d;
    logic             vs_fall;
    logic             vs_rise;
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_cur;
    logic             err_nxt;
    logic             accept;
    logic             in_range;
    logic             push;
    logic             drop_full;
    logic             close_frame;

    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [33:0]      mem [DEPTH];
    logic [33:0]      head;
    logic             full;
    logic             empty;
    logic             pop;

    assign vs_fall  = ~camera_vsync & vsync_d;
    assign vs_rise  = camera_vsync & ~vsync_d;
    assign accept   = (state == ST_ACTIVE) & in_req;
    assign in_range = cur_cnt < FRAME_CNT;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cur_cnt;
        err_nxt     = err_cur;
        push        = 1'b0;
        drop_full   = 1'b0;
        close_frame = 1'b0;

        // Words past the FIFO limit still advance the index so later tags stay frame-aligned.
        if (accept) begin
            if (in_range) begin
                cnt_nxt = cur_cnt + 1'b1;
                if (full) begin
                    drop_full = 1'b1;
                    err_nxt   = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end else begin
                err_nxt = 1'b1;
                if (cur_cnt != CNT_MAX) begin
                    cnt_nxt = cur_cnt + 1'b1;
                end
            end
        end

        case (state)
            ST_IDLE: begin
                if (init_done & camera_vsync) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (vs_fall) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (vs_rise) begin
                    state_nxt   = ST_WAIT;
                    close_frame = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge camera_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vsync_d    <= 1'b0;
            cur_cnt    <= '0;
            err_cur    <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            word_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            vsync_d    <= camera_vsync;
            cur_cnt    <= cnt_nxt;
            err_cur    <= err_nxt;
            frame_done <= close_frame;
            if (close_frame) begin
                word_cnt  <= cnt_nxt;
                frame_err <= (cnt_nxt != FRAME_CNT) | err_nxt;
            end
            if (drop_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Full is taken before this cycle's pop, so a push into a full FIFO is dropped even if it drains.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign pop   = ~empty & out_ready;

    always_ff @(posedge camera_pclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge camera_pclk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= {(cur_cnt == LAST_IDX), (cur_cnt == '0), in_data};
        end
    end

    assign head      = mem[rd_ptr[FIFO_AW-1:0]];
    assign out_valid = ~empty;
    assign out_data  = empty ? 32'd0 : head[31:0];
    assign out_sof   = ~empty & head[32];
    assign out_eof   = ~empty & head[33];

endmodule

// File: tb/tb_ov9281_frame_packer.sv
// tb/tb_ov9281_frame_packer.sv - scoreboard bench for ov9281_frame_packer (8-word frames, 4-entry FIFO).
module tb_ov9281_frame_packer;

    localparam int FW    = 8;
    localparam int CW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          camera_pclk;
    logic          rst_n;
    logic          init_done;
    logic          camera_vsync;
    logic          in_req;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_sof;
    logic          out_eof;
    logic          frame_done;
    logic          frame_err;
    logic [CW-1:0] word_cnt;
    logic          overflow;

    ov9281_frame_packer #(
        .FRAME_WORDS(FW),
        .CNT_W      (CW),
        .FIFO_AW    (AW)
    ) dut (
        .camera_pclk (camera_pclk),
        .rst_n       (rst_n),
        .init_done   (init_done),
        .camera_vsync(camera_vsync),
        .in_req      (in_req),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .word_cnt    (word_cnt),
        .overflow    (overflow)
    );

    initial camera_pclk = 1'b0;
    always #5 camera_pclk = ~camera_pclk;

    int n_checks = 0;
    int n_pass   = 0;
    int pops     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [33:0] wq[$];
    int          fq_cnt[$];
    bit          fq_err[$];

    int m_state;
    bit m_vsd;
    int m_cnt;
    bit m_err;
    int m_occ;
    bit m_ovf;

    // Reference model: sees the same inputs the DUT samples at each rising edge.
    always @(posedge camera_pclk) begin
        if (!rst_n) begin
            m_state = 0;
            m_vsd   = 0;
            m_cnt   = 0;
            m_err   = 0;
            m_occ   = 0;
            m_ovf   = 0;
            wq.delete();
            fq_cnt.delete();
            fq_err.delete();
        end else begin
            bit fall;
            bit rise;
            bit pop_now;
            fall    = !camera_vsync && m_vsd;
            rise    = camera_vsync && !m_vsd;
            pop_now = (m_occ > 0) && out_ready;
            if (m_state == 2 && in_req) begin
                if (m_cnt < FW) begin
                    if (m_occ < DEPTH) begin
                        wq.push_back({(m_cnt == FW - 1), (m_cnt == 0), in_data});
                        m_occ++;
                    end else begin
                        m_err = 1;
                        m_ovf = 1;
                    end
                    m_cnt++;
                end else begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            if (pop_now) m_occ--;
            case (m_state)
                0: if (init_done && camera_vsync) m_state = 1;
                1: if (fall) begin
                    m_state = 2;
                    m_cnt   = 0;
                    m_err   = 0;
                end
                2: if (rise) begin
                    fq_cnt.push_back(m_cnt);
                    fq_err.push_back(m_err || (m_cnt != FW));
                    m_state = 1;
                end
                default: m_state = 0;
            endcase
            m_vsd = camera_vsync;
        end
    end

    always @(negedge camera_pclk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                pops++;
                if (wq.size() == 0) begin
                    check("unexp_word", 1, 0);
                end else begin
                    logic [33:0] e;
                    e = wq.pop_front();
                    check("out_data", out_data, e[31:0]);
                    check("out_sof", out_sof, e[32]);
                    check("out_eof", out_eof, e[33]);
                end
            end
            if (frame_done) begin
                if (fq_cnt.size() == 0) begin
                    check("unexp_frame_done", 1, 0);
                end else begin
                    check("word_cnt", word_cnt, fq_cnt.pop_front());
                    check("frame_err", frame_err, fq_err.pop_front());
                end
            end
        end
    end

    task automatic step(input logic vs, input logic req, input logic [31:0] d);
        @(posedge camera_pclk);
        #1;
        camera_vsync = vs;
        in_req       = req;
        in_data      = d;
    endtask

    task automatic frame(input int n, input logic [31:0] base);
        step(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, base + 32'(i));
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
    endtask

    task automatic drain(input string tag);
        int k;
        out_ready = 1'b1;
        k = 0;
        while ((wq.size() != 0 || fq_cnt.size() != 0) && k < 100) begin
            @(negedge camera_pclk);
            k++;
        end
        check(tag, 64'(wq.size() + fq_cnt.size()), 0);
    endtask

    task automatic do_reset();
        @(posedge camera_pclk);
        #3;
        rst_n        = 1'b0;
        in_req       = 1'b0;
        camera_vsync = 1'b1;
        repeat (2) @(posedge camera_pclk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_sof"}, out_sof, 0);
        check({tag, "_eof"}, out_eof, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_err"}, frame_err, 0);
        check({tag, "_cnt"}, word_cnt, 0);
        check({tag, "_ovf"}, overflow, 0);
    endtask

    initial begin
        int p0;
        rst_n        = 1'b0;
        init_done    = 1'b0;
        camera_vsync = 1'b0;
        in_req       = 1'b0;
        in_data      = 32'd0;
        out_ready    = 1'b1;
        repeat (2) @(posedge camera_pclk);
        #1;
        check_all_zero("rst");
        rst_n        = 1'b1;
        init_done    = 1'b1;
        camera_vsync = 1'b1;
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);

        // clean frame
        frame(8, 32'h100);
        drain("t1_drain");
        check("t1_cnt", word_cnt, 8);
        check("t1_err", frame_err, 0);
        check("t1_ovf", overflow, 0);

        // FIFO overflow with downstream stalled
        out_ready = 1'b0;
        frame(6, 32'h200);
        check("t2_ovf", overflow, 1);
        drain("t2_drain");
        check("t2_cnt", word_cnt, 6);
        check("t2_err", frame_err, 1);

        // short frame, then zero-word frame
        frame(5, 32'h300);
        drain("t3_drain");
        check("t3_cnt", word_cnt, 5);
        check("t3_err", frame_err, 1);
        frame(0, 32'h0);
        drain("t3z_drain");
        check("t3z_cnt", word_cnt, 0);
        check("t3z_err", frame_err, 1);

        // long frame after clearing the sticky overflow
        do_reset();
        check("t4_ovf_clr", overflow, 0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        frame(10, 32'h400);
        drain("t4_drain");
        check("t4_cnt", word_cnt, 10);
        check("t4_err", frame_err, 1);
        check("t4_ovf", overflow, 0);

        // sustained push+pop with three words resident
        out_ready = 1'b0;
        step(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h700 + 32'(i));
        p0 = pops;
        for (int i = 3; i < 8; i++) begin
            @(posedge camera_pclk);
            #1;
            out_ready = 1'b1;
            in_req    = 1'b1;
            in_data   = 32'h700 + 32'(i);
        end
        @(posedge camera_pclk);
        #1;
        check("t6_tput", 64'(pops - p0), 5);
        camera_vsync = 1'b1;
        in_req       = 1'b0;
        step(1'b1, 1'b0, 32'd0);
        drain("t6_drain");
        check("t6_cnt", word_cnt, 8);
        check("t6_err", frame_err, 0);
        check("t6_ovf", overflow, 0);

        // start mid-frame, then clean frame, then reset with data buffered
        init_done = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h500 + 32'(i));
        init_done = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h510 + 32'(i));
        step(1'b0, 1'b0, 32'd0);
        check("t5_mid_valid", out_valid, 0);
        check("t5_mid_q", 64'(wq.size()), 0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        frame(8, 32'h600);
        drain("t5_drain");
        check("t5_cnt", word_cnt, 8);
        check("t5_err", frame_err, 0);
        out_ready = 1'b0;
        step(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h680 + 32'(i));
        step(1'b0, 1'b0, 32'd0);
        check("t5_pre_valid", out_valid, 1);
        @(posedge camera_pclk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_rst");
        repeat (2) @(posedge camera_pclk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge camera_pclk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
